// File: rtl/matrix_pkg.sv
// Shared types and default geometry for the matrix dibit link.
// Used by both the compiler (transmit) and decompiler (receive) sides.
package matrix_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    localparam int DEF_ELEM_SIZE = 8;
    localparam int DEF_SIZE_A    = 32;
    localparam int DEF_SIZE_B    = 32;
    localparam int DEF_GAP_LIMIT = 16;

    localparam int DIBITS = DEF_ELEM_SIZE / 2;
    localparam int ROW_W  = $clog2(DEF_SIZE_A);
    localparam int COL_W  = $clog2(DEF_SIZE_B);
    localparam int ADDR_W = $clog2(DEF_SIZE_A * DEF_SIZE_B);

    // Counter width that never collapses to zero bits.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_if.sv
// Dibit input and tagged-element output bundle of the matrix link receiver.
// slave is the receiver side, master the stream source / element consumer.
interface matrix_if
    import matrix_pkg::*;
#(
    parameter int EW = DEF_ELEM_SIZE,
    parameter int RW = ROW_W,
    parameter int CW = COL_W
);
    logic          valid_data_in;
    logic [1:0]    dibit;
    logic [RW-1:0] row_addr;
    logic [CW-1:0] col_addr;
    logic [EW-1:0] matrix_element;
    logic          valid_data_out;
    logic          matrix_done;
    logic          frame_error;
    logic          busy;

    modport master (
        output valid_data_in, dibit,
        input  row_addr, col_addr, matrix_element,
        input  valid_data_out, matrix_done, frame_error, busy
    );

    modport slave (
        input  valid_data_in, dibit,
        output row_addr, col_addr, matrix_element,
        output valid_data_out, matrix_done, frame_error, busy
    );

endinterface

// File: rtl/matrix_decompiler_dibit_deserializer.sv
// MSB-first dibit shift register with dibit counter.
// element/element_ready are combinational views of the dibit being loaded.
module dibit_deserializer
    import matrix_pkg::*;
#(
    parameter int ELEM_W = DEF_ELEM_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [1:0]        dibit,
    output logic              element_ready,
    output logic [ELEM_W-1:0] element
);

    localparam int DIB   = ELEM_W / 2;
    localparam int CNT_W = cnt_w(DIB);

    logic [ELEM_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        element       = (shift_q << 2) | ELEM_W'(dibit);
        element_ready = load && (cnt_q == CNT_W'(DIB - 1));
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (load) begin
            shift_d = element;
            cnt_d   = element_ready ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/matrix_decompiler.sv
// Receive side of the matrix dibit link: rebuilds row-major tagged elements,
// flags frame completion and aborts frames that stall past GAP_LIMIT cycles.
module matrix_decompiler
    import matrix_pkg::*;
#(
    parameter int MAX_ELEMENT_SIZE = DEF_ELEM_SIZE,
    parameter int MAX_SIZE_A       = DEF_SIZE_A,
    parameter int MAX_SIZE_B       = DEF_SIZE_B,
    parameter int GAP_LIMIT        = DEF_GAP_LIMIT
) (
    input  logic     eth_refclk,
    input  logic     rst_n,
    matrix_if.slave  bus
);

    localparam int RW    = cnt_w(MAX_SIZE_A);
    localparam int CW    = cnt_w(MAX_SIZE_B);
    localparam int EW    = MAX_ELEMENT_SIZE;
    localparam int GAP_W = $clog2(GAP_LIMIT + 1);

    state_e         state_q, state_d;
    logic [RW-1:0]  row_q, row_d;
    logic [CW-1:0]  col_q, col_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [RW-1:0]  ra_q, ra_d;
    logic [CW-1:0]  ca_q, ca_d;
    logic [EW-1:0]  elem_q, elem_d;
    logic           vout_q, vout_d;
    logic           done_q, done_d;
    logic           ferr_q, ferr_d;
    logic           busy_q, busy_d;

    logic           load;
    logic           clear;
    logic           ready;
    logic [EW-1:0]  elem_w;
    logic           last_elem;

    dibit_deserializer #(
        .ELEM_W (EW)
    ) u_deser (
        .clk           (eth_refclk),
        .rst_n         (rst_n),
        .load          (load),
        .clear         (clear),
        .dibit         (bus.dibit),
        .element_ready (ready),
        .element       (elem_w)
    );

    assign last_elem = (row_q == RW'(MAX_SIZE_A - 1)) &&
                       (col_q == CW'(MAX_SIZE_B - 1));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        gap_d   = gap_q;
        ra_d    = ra_q;
        ca_d    = ca_q;
        elem_d  = elem_q;
        vout_d  = 1'b0;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        load    = 1'b0;
        clear   = 1'b0;
        // A valid dibit is consumed in either state; IDLE always has cleared counters.
        if (bus.valid_data_in) begin
            load    = 1'b1;
            gap_d   = '0;
            state_d = RECV;
            if (ready) begin
                vout_d = 1'b1;
                elem_d = elem_w;
                ra_d   = row_q;
                ca_d   = col_q;
                if (last_elem) begin
                    done_d  = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = IDLE;
                end else if (col_q == CW'(MAX_SIZE_B - 1)) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end else if (state_q == RECV) begin
            if (gap_q == GAP_W'(GAP_LIMIT - 1)) begin
                ferr_d  = 1'b1;
                clear   = 1'b1;
                row_d   = '0;
                col_d   = '0;
                gap_d   = '0;
                state_d = IDLE;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end
        busy_d = (state_d == RECV);
    end

    always_ff @(posedge eth_refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            gap_q   <= '0;
            ra_q    <= '0;
            ca_q    <= '0;
            elem_q  <= '0;
            vout_q  <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            gap_q   <= gap_d;
            ra_q    <= ra_d;
            ca_q    <= ca_d;
            elem_q  <= elem_d;
            vout_q  <= vout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.row_addr       = ra_q;
    assign bus.col_addr       = ca_q;
    assign bus.matrix_element = elem_q;
    assign bus.valid_data_out = vout_q;
    assign bus.matrix_done    = done_q;
    assign bus.frame_error    = ferr_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_matrix_decompiler.sv
// Bench for matrix_decompiler: element-index reference model, per-cycle
// compare of every output, directed scenarios then random stream.
module tb_matrix_decompiler;

    localparam int NA  = 32;
    localparam int NB  = 32;
    localparam int DIB = 4;
    localparam int GAP = 16;

    logic clk;
    logic rst_n;

    matrix_if #(.EW(8), .RW(5), .CW(5)) bus ();

    matrix_decompiler dut (
        .eth_refclk (clk),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state (element index k within the frame)
    int in_frame, k, dcnt, acc, idle;
    int e_vout, e_done, e_ferr, e_busy, e_row, e_col, e_elem;

    int n_vout, n_done, n_ferr;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        in_frame = 0; k = 0; dcnt = 0; acc = 0; idle = 0;
        e_vout = 0; e_done = 0; e_ferr = 0; e_busy = 0;
        e_row = 0; e_col = 0; e_elem = 0;
    endtask

    task automatic model_step(input int v, input int d);
        e_vout = 0; e_done = 0; e_ferr = 0;
        if (v != 0) begin
            if (in_frame == 0) begin
                in_frame = 1; k = 0; dcnt = 0; acc = 0;
            end
            idle = 0;
            acc  = (acc * 4 + d) & 255;
            dcnt++;
            if (dcnt == DIB) begin
                e_vout = 1;
                e_elem = acc;
                e_row  = k / NB;
                e_col  = k % NB;
                e_done = (k == NA * NB - 1) ? 1 : 0;
                k++;
                dcnt = 0;
                acc  = 0;
                if (e_done != 0) in_frame = 0;
            end
        end else if (in_frame != 0) begin
            idle++;
            if (idle == GAP) begin
                e_ferr   = 1;
                in_frame = 0;
            end
        end
        e_busy = in_frame;
    endtask

    task automatic drive(input int v, input int d);
        bus.valid_data_in = (v != 0);
        bus.dibit         = 2'(d);
        @(posedge clk);
        model_step(v, d);
        #1;
    endtask

    task automatic send_elem(input logic [7:0] val);
        for (int i = DIB - 1; i >= 0; i--) drive(1, int'(val[2*i +: 2]));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_vout"}, bus.valid_data_out, 0);
        check({tag, "_done"}, bus.matrix_done, 0);
        check({tag, "_ferr"}, bus.frame_error, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_row"}, bus.row_addr, 0);
        check({tag, "_col"}, bus.col_addr, 0);
        check({tag, "_elem"}, bus.matrix_element, 0);
    endtask

    // per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("vout", bus.valid_data_out, e_vout);
                check("done", bus.matrix_done, e_done);
                check("ferr", bus.frame_error, e_ferr);
                check("busy", bus.busy, e_busy);
                check("row", bus.row_addr, e_row);
                check("col", bus.col_addr, e_col);
                check("elem", bus.matrix_element, e_elem);
                if (bus.valid_data_out) begin
                    n_vout++;
                    if (n_vout == 33) begin
                        check("pulse33_row", bus.row_addr, 1);
                        check("pulse33_col", bus.col_addr, 0);
                    end
                end
                if (bus.matrix_done) begin
                    n_done++;
                    check("done_row", bus.row_addr, 31);
                    check("done_col", bus.col_addr, 31);
                end
                if (bus.frame_error) n_ferr++;
            end
        end
    end

    initial begin
        int fe0;
        int pv;
        n_vout = 0; n_done = 0; n_ferr = 0;
        rst_n = 1'b0;
        bus.valid_data_in = 1'b0;
        bus.dibit = 2'b00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        drive(0, 0);

        // single element B1
        drive(1, 2); drive(1, 3); drive(1, 0); drive(1, 1);
        @(negedge clk);
        check("single_vout", bus.valid_data_out, 1);
        check("single_elem", bus.matrix_element, 8'hB1);
        check("single_model", e_elem, 8'hB1);
        check("single_row", bus.row_addr, 0);
        check("single_col", bus.col_addr, 0);
        check("single_busy", bus.busy, 1);
        repeat (20) drive(0, 0);
        check("single_abort", n_ferr, 1);

        // two back-to-back full frames
        n_vout = 0; n_done = 0;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < NA * NB; i++) send_elem(8'(i));
        drive(0, 0);
        @(negedge clk);
        check("frames_busy", bus.busy, 0);
        check("frames_pulses", n_vout, 2048);
        check("frames_done", n_done, 2);

        // short gap inside element (0,4)
        fe0 = n_ferr;
        for (int i = 0; i < 4; i++) send_elem(8'($urandom));
        drive(1, 1); drive(1, 2);
        repeat (5) drive(0, 0);
        drive(1, 3); drive(1, 0);
        @(negedge clk);
        check("gap_elem", bus.matrix_element, 8'h6C);
        check("gap_col4", bus.col_addr, 4);
        send_elem(8'h5A);
        @(negedge clk);
        check("gap_row", bus.row_addr, 0);
        check("gap_col5", bus.col_addr, 5);
        check("gap_noerr", n_ferr, fe0);

        // long gap mid-element
        drive(1, 3); drive(1, 1);
        repeat (GAP) drive(0, 0);
        @(negedge clk);
        check("long_ferr", bus.frame_error, 1);
        check("long_busy", bus.busy, 0);
        check("long_count", n_ferr, fe0 + 1);
        send_elem(8'h3A);
        @(negedge clk);
        check("restart_row", bus.row_addr, 0);
        check("restart_col", bus.col_addr, 0);
        check("restart_elem", bus.matrix_element, 8'h3A);

        // reset mid-frame
        for (int i = 0; i < 10; i++) send_elem(8'($urandom));
        drive(1, 2); drive(1, 1);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        bus.valid_data_in = 1'b0;
        rst_n = 1'b1;
        pv = n_vout;
        repeat (3) drive(0, 0);
        check("midrst_nostale", n_vout, pv);
        send_elem(8'hC5);
        @(negedge clk);
        check("midrst_row", bus.row_addr, 0);
        check("midrst_col", bus.col_addr, 0);
        check("midrst_elem", bus.matrix_element, 8'hC5);

        // random stream with occasional long stalls
        repeat (4000) begin
            if ($urandom_range(0, 199) == 0)
                repeat ($urandom_range(10, 20)) drive(0, 0);
            drive(($urandom_range(0, 99) < 85) ? 1 : 0, int'($urandom_range(0, 3)));
        end
        repeat (GAP + 2) drive(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
